// File: rtl/video_timing_pkg.sv
// Shared video timing constants and helpers for the sync generator and its counters.
// Holds the default counter width plus the standard 1080p60 and 720p60 raster parameters.
package video_timing_pkg;

    localparam int VT_CNT_W = 12;

    // CEA-861 1080p60 raster, pixel clock 148.5 MHz
    localparam int H1080_ACTIVE = 1920;
    localparam int H1080_FP     = 88;
    localparam int H1080_SYNC   = 44;
    localparam int H1080_BP     = 148;
    localparam int V1080_ACTIVE = 1080;
    localparam int V1080_FP     = 4;
    localparam int V1080_SYNC   = 5;
    localparam int V1080_BP     = 36;

    // CEA-861 720p60 raster, pixel clock 74.25 MHz
    localparam int H720_ACTIVE  = 1280;
    localparam int H720_FP      = 110;
    localparam int H720_SYNC    = 40;
    localparam int H720_BP      = 220;
    localparam int V720_ACTIVE  = 720;
    localparam int V720_FP      = 5;
    localparam int V720_SYNC    = 5;
    localparam int V720_BP      = 20;

    function automatic int f_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis counter: counts 0..TOTAL-1 on iInc, flags the wrap cycle combinationally.
// iClr parks the counter at zero, used to hold the raster at start-of-frame.
module video_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int TOTAL = 16,
    parameter int CNT_W = VT_CNT_W
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iClr,
    input  logic             iInc,
    output logic [CNT_W-1:0] oCnt,
    output logic             oWrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt;

    // oWrap is only meaningful when the axis actually advances this clock
    assign oWrap = iInc && (cnt == LAST);
    assign oCnt  = cnt;

    always_ff @(posedge iClk) begin
        if (iReset || iClr) begin
            cnt <= '0;
        end else if (oWrap) begin
            cnt <= '0;
        end else if (iInc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// Source-side raster timing generator: HSYNC/VSYNC/DE plus frame-start marker and pixel position.
// Vsync edges are re-timed onto the hsync leading edge so a frame-sync detector sees one clean event.
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int CNT_W    = VT_CNT_W,
    parameter int H_ACTIVE = H1080_ACTIVE,
    parameter int H_FP     = H1080_FP,
    parameter int H_SYNC   = H1080_SYNC,
    parameter int H_BP     = H1080_BP,
    parameter int V_ACTIVE = V1080_ACTIVE,
    parameter int V_FP     = V1080_FP,
    parameter int V_SYNC   = V1080_SYNC,
    parameter int V_BP     = V1080_BP,
    parameter int SYNC_POL = 1
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iEn,
    output logic             oHsyn,
    output logic             oVsyn,
    output logic             oDe,
    output logic             oFrameStart,
    output logic [CNT_W-1:0] oHcnt,
    output logic [CNT_W-1:0] oVcnt
);

    localparam int H_TOTAL  = f_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = f_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(HS_START + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(VS_START);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(VS_START + V_SYNC - 1);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [CNT_W-1:0] hCnt;
    logic [CNT_W-1:0] vCnt;
    logic             hWrap;
    logic             unusedVWrap;

    logic             hsDec;
    logic             deDec;
    logic             fsDec;
    logic             vsRange;
    logic             vsFlag;
    logic             vsNext;

    video_axis_cnt #(
        .TOTAL (H_TOTAL),
        .CNT_W (CNT_W)
    ) hAxis (
        .iClk   (iClk),
        .iReset (iReset),
        .iClr   (~iEn),
        .iInc   (iEn),
        .oCnt   (hCnt),
        .oWrap  (hWrap)
    );

    video_axis_cnt #(
        .TOTAL (V_TOTAL),
        .CNT_W (CNT_W)
    ) vAxis (
        .iClk   (iClk),
        .iReset (iReset),
        .iClr   (~iEn),
        .iInc   (hWrap & iEn),
        .oCnt   (vCnt),
        .oWrap  (unusedVWrap)
    );

    assign hsDec   = (hCnt >= HS_START_C) && (hCnt <= HS_END_C);
    assign deDec   = (hCnt < H_ACT_C) && (vCnt < V_ACT_C);
    assign fsDec   = (hCnt == '0) && (vCnt == '0);
    assign vsRange = (vCnt >= VS_START_C) && (vCnt <= VS_END_C);

    // Vsync only changes state at the hsync leading pixel, keeping both edges hsync-aligned
    assign vsNext  = (hCnt == HS_START_C) ? vsRange : vsFlag;

    // Stream contract: oDe is the valid qualifier for oHcnt/oVcnt and there is no ready;
    // the raster advances every enabled clock and downstream must accept every oDe beat.
    always_ff @(posedge iClk) begin
        if (iReset || !iEn) begin
            vsFlag      <= 1'b0;
            oHsyn       <= SYNC_OFF;
            oVsyn       <= SYNC_OFF;
            oDe         <= 1'b0;
            oFrameStart <= 1'b0;
            oHcnt       <= '0;
            oVcnt       <= '0;
        end else begin
            vsFlag      <= vsNext;
            oHsyn       <= hsDec  ? SYNC_ON : SYNC_OFF;
            oVsyn       <= vsNext ? SYNC_ON : SYNC_OFF;
            oDe         <= deDec;
            oFrameStart <= fsDec;
            oHcnt       <= hCnt;
            oVcnt       <= vCnt;
        end
    end

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen on a 16x8 raster, run with both sync polarities side by side.
// The driver pushes hand-derived expected outputs per clock; a monitor pops and compares.
module tb_video_sync_gen;

    localparam int CNT_W = 12;
    // expected word: {check_counters, hs, vs, de, fs, x, y}
    localparam int W     = 1 + 4 + 2 * CNT_W;

    logic             iClk = 1'b0;
    logic             iReset = 1'b1;
    logic             iEn = 1'b1;

    logic             hsP, vsP, deP, fsP;
    logic [CNT_W-1:0] hcP, vcP;
    logic             hsN, vsN, deN, fsN;
    logic [CNT_W-1:0] hcN, vcN;

    video_sync_gen #(
        .CNT_W(CNT_W), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
    ) dutP (
        .iClk(iClk), .iReset(iReset), .iEn(iEn),
        .oHsyn(hsP), .oVsyn(vsP), .oDe(deP), .oFrameStart(fsP),
        .oHcnt(hcP), .oVcnt(vcP)
    );

    video_sync_gen #(
        .CNT_W(CNT_W), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
    ) dutN (
        .iClk(iClk), .iReset(iReset), .iEn(iEn),
        .oHsyn(hsN), .oVsyn(vsN), .oDe(deN), .oFrameStart(fsN),
        .oHcnt(hcN), .oVcnt(vcN)
    );

    // ---------------- clock ----------------
    always #5 iClk = ~iClk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cnt_de = 0;
    int           cnt_fs = 0;
    int           mx = 0;
    int           my = 0;

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic en, input string nm);
        logic [W-1:0] e;
        logic hs, vs, de, fs;
        @(negedge iClk);
        iReset = rst;
        iEn    = en;
        if (rst || !en) begin
            e  = {1'b1, 4'b0000, {CNT_W{1'b0}}, {CNT_W{1'b0}}};
            mx = 0;
            my = 0;
        end else begin
            // 16-pixel line: active 0..7, hsync 10..12; 8-line frame: active 0..3, vsync lines 5..6
            // re-timed to pixel 10, so it spans (10,5) through (9,7).
            hs = (mx >= 10) && (mx <= 12);
            vs = ((my == 5) && (mx >= 10)) || (my == 6) || ((my == 7) && (mx < 10));
            de = (mx < 8) && (my < 4);
            fs = (mx == 0) && (my == 0);
            e  = {de, hs, vs, de, fs, CNT_W'(mx), CNT_W'(my)};
            mx++;
            if (mx == 16) begin
                mx = 0;
                my++;
                if (my == 8) my = 0;
            end
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic report(input string nm, input int pol, input logic [W-2:0] got,
                          input logic [W-2:0] want);
        $display("FAIL %s pol=%0d got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d exp hs=%b vs=%b de=%b fs=%b x=%0d y=%0d",
                 nm, pol, got[W-2], got[W-3], got[W-4], got[W-5], got[2*CNT_W-1:CNT_W], got[CNT_W-1:0],
                 want[W-2], want[W-3], want[W-4], want[W-5], want[2*CNT_W-1:CNT_W], want[CNT_W-1:0]);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0]   e;
        logic [W-2:0]   gotP, gotN, expP, expN;
        logic [W-2:0]   polMask;
        logic           prevVs, prevHs;
        string          nm;
        polMask = {2'b11, {(W - 3){1'b0}}};
        prevVs  = 1'b0;
        prevHs  = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            if (deP === 1'b1) cnt_de++;
            if (fsP === 1'b1) cnt_fs++;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                nm   = name_q.pop_front();
                expP = e[W-2:0];
                expN = expP ^ polMask;
                gotP = {hsP, vsP, deP, fsP, hcP, vcP};
                gotN = {hsN, vsN, deN, fsN, hcN, vcN};
                if (!e[W-1]) begin
                    // position is only defined while oDe is high
                    expP[2*CNT_W-1:0] = '0;
                    expN[2*CNT_W-1:0] = '0;
                    gotP[2*CNT_W-1:0] = '0;
                    gotN[2*CNT_W-1:0] = '0;
                end
                checks++;
                if (gotP !== expP) begin
                    errors++;
                    report(nm, 1, gotP, expP);
                end
                checks++;
                if (gotN !== expN) begin
                    errors++;
                    report(nm, 0, gotN, expN);
                end
            end
            if (iReset === 1'b0 && iEn === 1'b1 && vsP !== prevVs) begin
                checks++;
                if (!(hsP === 1'b1 && prevHs === 1'b0)) begin
                    errors++;
                    $display("FAIL vsync_edge_align got vs=%b hs=%b prev_hs=%b exp hs rising",
                             vsP, hsP, prevHs);
                end
            end
            prevVs = vsP;
            prevHs = hsP;
        end
    end

    // ---------------- stimulus and final report ----------------
    initial begin
        int de_base, fs_base;
        repeat (5) step(1'b1, 1'b1, "reset_hold");

        de_base = cnt_de;
        fs_base = cnt_fs;
        repeat (384) step(1'b0, 1'b1, "free_run");
        checks++;
        if (cnt_de - de_base != 96) begin
            errors++;
            $display("FAIL de_per_3_frames got=%0d exp=96", cnt_de - de_base);
        end
        checks++;
        if (cnt_fs - fs_base != 3) begin
            errors++;
            $display("FAIL framestart_per_3_frames got=%0d exp=3", cnt_fs - fs_base);
        end

        repeat (35)  step(1'b0, 1'b1, "pre_en_drop");
        repeat (4)   step(1'b0, 1'b0, "en_low");
        repeat (128) step(1'b0, 1'b1, "en_restart");

        repeat (98)  step(1'b0, 1'b1, "to_mid_vsync");
        step(1'b1, 1'b1, "reset_mid_vsync");
        repeat (140) step(1'b0, 1'b1, "after_reset");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge iClk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
